// File: rtl/rr_arb2x1.sv
// Two-requester round-robin arbiter feeding a one-entry registered output stage.
// Drain and refill may occur on the same edge, so the block sustains one word per cycle.
module rr_arb2x1 #(
    parameter int DATAWIDTH = 64
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATAWIDTH-1:0] a,
    input  logic                 a_req,
    output logic                 a_ack,
    input  logic [DATAWIDTH-1:0] b,
    input  logic                 b_req,
    output logic                 b_ack,
    output logic [DATAWIDTH-1:0] d,
    output logic                 d_valid,
    input  logic                 d_ready,
    output logic                 d_src
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [DATAWIDTH-1:0]   d_q, d_d;
    logic                   d_src_q, d_src_d;
    logic                   last_q, last_d;
    logic                   can_accept;
    logic                   grant_a, grant_b;

    // On contention the requester that was not granted last wins.
    assign grant_a = a_req & (~b_req | last_q);
    assign grant_b = b_req & (~a_req | ~last_q);

    always_comb begin
        state_d    = state_q;
        d_d        = d_q;
        d_src_d    = d_src_q;
        last_d     = last_q;
        can_accept = (state_q == EMPTY) | d_ready;
        a_ack      = grant_a & can_accept & ~Rst;
        b_ack      = grant_b & can_accept & ~Rst;

        if (a_ack || b_ack) begin
            state_d = FULL;
            d_d     = b_ack ? b : a;
            d_src_d = b_ack;
            last_d  = b_ack;
        end else if (state_q == FULL && d_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= EMPTY;
            d_q     <= '0;
            d_src_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            d_src_q <= d_src_d;
            last_q  <= last_d;
        end
    end

    assign d       = d_q;
    assign d_valid = (state_q == FULL);
    assign d_src   = d_src_q;

endmodule

// File: tb/tb_rr_arb2x1.sv
// Bench for rr_arb2x1: directed scenarios then random traffic, all checked
// against a transaction-level model of the arbiter and output register.
module tb_rr_arb2x1;

    localparam int DW = 64;

    logic          Clk = 1'b0;
    logic          Rst;
    logic [DW-1:0] a, b, d;
    logic          a_req, b_req, a_ack, b_ack;
    logic          d_valid, d_ready, d_src;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [DW-1:0] m_d;
    logic          m_valid, m_src, m_last;
    logic          seen_a_ack, seen_b_ack;

    always #5 Clk = ~Clk;

    rr_arb2x1 #(.DATAWIDTH(DW)) dut (
        .Clk(Clk), .Rst(Rst),
        .a(a), .a_req(a_req), .a_ack(a_ack),
        .b(b), .b_req(b_req), .b_ack(b_ack),
        .d(d), .d_valid(d_valid), .d_ready(d_ready), .d_src(d_src)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: check acks mid-cycle, advance model on the edge, check outputs after it.
    task automatic cycle(input string tag);
        logic can, any, winner, ea, eb;
        @(negedge Clk);
        can    = !m_valid || d_ready;
        any    = a_req || b_req;
        winner = (a_req && b_req) ? !m_last : b_req;   // 0 = A, 1 = B
        ea     = !Rst && can && any && !winner;
        eb     = !Rst && can && any && winner;
        chk({tag, ".a_ack"}, {63'b0, a_ack}, {63'b0, ea});
        chk({tag, ".b_ack"}, {63'b0, b_ack}, {63'b0, eb});
        @(posedge Clk);
        if (Rst) begin
            m_d = '0; m_valid = 0; m_src = 0; m_last = 1;
        end else if (ea || eb) begin
            m_d = winner ? b : a; m_valid = 1; m_src = winner; m_last = winner;
        end else if (m_valid && d_ready) begin
            m_valid = 0;
        end
        seen_a_ack = ea;
        seen_b_ack = eb;
        #1;
        chk({tag, ".d"}, d, m_d);
        chk({tag, ".d_valid"}, {63'b0, d_valid}, {63'b0, m_valid});
        chk({tag, ".d_src"}, {63'b0, d_src}, {63'b0, m_src});
    endtask

    task automatic do_reset();
        Rst = 1; a_req = 0; b_req = 0; d_ready = 0;
        cycle("rst");
        Rst = 0;
    endtask

    initial begin
        Rst = 1; a = '0; b = '0; a_req = 0; b_req = 0; d_ready = 0;
        m_d = '0; m_valid = 0; m_src = 0; m_last = 1;
        seen_a_ack = 0; seen_b_ack = 0;
        @(posedge Clk); #1;
        do_reset();

        // Single A request captured on the first edge after reset
        a_req = 1; a = 64'h11; d_ready = 1;
        cycle("single_a");
        a_req = 0;

        // Continuous contention alternates A,B,A,B
        do_reset();
        a_req = 1; b_req = 1; a = 64'hA; b = 64'hB; d_ready = 1;
        for (int i = 0; i < 4; i++) cycle("alt");
        a_req = 0; b_req = 0;

        // Back-pressure while full, then release
        do_reset();
        a_req = 1; a = 64'h11; d_ready = 1;
        cycle("fill");
        a_req = 0; b_req = 1; b = 64'h22; d_ready = 0;
        for (int i = 0; i < 3; i++) cycle("stall");
        d_ready = 1;
        cycle("release");
        b_req = 0;

        // Drain with no request
        cycle("drain");

        // Reset while full discards the word; A then wins contention
        a_req = 1; a = 64'h33;
        cycle("refill");
        Rst = 1;
        cycle("rst_full");
        Rst = 0; b_req = 1; b = 64'h44;
        cycle("post_rst");
        a_req = 0; b_req = 0;

        // Grant B, idle, then contention goes to A
        do_reset();
        b_req = 1; b = 64'h55; d_ready = 1;
        cycle("grant_b");
        b_req = 0;
        for (int i = 0; i < 5; i++) cycle("idle");
        a_req = 1; b_req = 1; a = 64'h66; b = 64'h77;
        cycle("after_idle");
        a_req = 0; b_req = 0;

        // Random traffic; requesters hold req and data until acked
        seen_a_ack = 1; seen_b_ack = 1;
        for (int i = 0; i < 500; i++) begin
            if (seen_a_ack || !a_req) begin
                a_req = 1'($urandom_range(0, 1));
                a = {$urandom, $urandom};
            end
            if (seen_b_ack || !b_req) begin
                b_req = 1'($urandom_range(0, 1));
                b = {$urandom, $urandom};
            end
            d_ready = ($urandom_range(0, 3) != 0);
            Rst = ($urandom_range(0, 39) == 0);
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
